// File: rtl/prores_entropy_pkg.sv
// Shared types and constants for the ProRes entropy encoders.
package prores_entropy_pkg;

  typedef enum logic [2:0] {
    CB_FIRST,
    CB_EG0,
    CB_EG1,
    CB_HYB,
    CB_EG3
  } codebook_e;

  localparam int unsigned FIRST_PREV_DIFF = 3;
  localparam int unsigned HYB_RICE_K      = 2;
  localparam int unsigned HYB_EG_K        = 3;
  localparam int unsigned HYB_THRESH      = 8;

  // Exp-Golomb order used by a codebook (the hybrid's escape uses HYB_EG_K).
  function automatic int unsigned eg_order(input codebook_e cb, input int unsigned first_k);
    int unsigned k;
    case (cb)
      CB_FIRST: k = first_k;
      CB_EG0:   k = 0;
      CB_EG1:   k = 1;
      CB_HYB:   k = HYB_EG_K;
      CB_EG3:   k = 3;
      default:  k = 0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/prores_codeword_gen.sv
// Combinational (symbol, codebook) -> right-aligned codeword and bit length.
module prores_codeword_gen
  import prores_entropy_pkg::*;
#(
  parameter int unsigned SYM_W   = 22,
  parameter int unsigned CW_W    = 48,
  parameter int unsigned LEN_W   = 6,
  parameter int unsigned FIRST_K = 5
) (
  input  logic [SYM_W-1:0] sym,
  input  codebook_e        cb,
  output logic [CW_W-1:0]  code,
  output logic [LEN_W-1:0] len
);

  localparam int unsigned W_W = SYM_W + 1;

  logic             hyb_rice;
  logic             hyb_eg;
  logic [SYM_W-1:0] eg_sym;
  logic [W_W-1:0]   w;
  int unsigned      k;
  int unsigned      msb;

  // Exp-Golomb: w = s + 2^k, length 2*floor(log2 w) - k + 1; hybrid adds a Rice prefix path.
  always_comb begin
    hyb_rice = (cb == CB_HYB) && (sym < SYM_W'(HYB_THRESH));
    hyb_eg   = (cb == CB_HYB) && !hyb_rice;
    k        = eg_order(cb, FIRST_K);
    eg_sym   = hyb_eg ? (sym - SYM_W'(HYB_THRESH)) : sym;
    w        = W_W'(eg_sym) + (W_W'(1) << k);
    msb      = 0;
    for (int i = 0; i < W_W; i++) begin
      if (w[i]) msb = unsigned'(i);
    end
    if (hyb_rice) begin
      code = CW_W'({1'b1, sym[HYB_RICE_K-1:0]});
      len  = LEN_W'(32'(sym >> HYB_RICE_K) + HYB_RICE_K + 1);
    end else if (hyb_eg) begin
      // Two leading zero bits are implied by the extra length only.
      code = CW_W'(w);
      len  = LEN_W'(2 * msb - k + 3);
    end else begin
      code = CW_W'(w);
      len  = LEN_W'(2 * msb - k + 1);
    end
  end

endmodule

// File: rtl/prores_dc_entropy_encoder.sv
// ProRes DC entropy encoder: per-component prediction, sign adaptation, adaptive codebooks.
module prores_dc_entropy_encoder
  import prores_entropy_pkg::*;
#(
  parameter int unsigned COEFF_W  = 20,
  parameter int unsigned NUM_COMP = 3,
  parameter int unsigned FIRST_K  = 5,
  parameter int unsigned CW_W     = 48,
  parameter int unsigned LEN_W    = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [COEFF_W-1:0]   in_dc,
  input  logic [$clog2(NUM_COMP)-1:0] in_comp,
  input  logic                        in_first,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CW_W-1:0]             out_code,
  output logic [LEN_W-1:0]            out_len,
  output logic [$clog2(NUM_COMP)-1:0] out_comp,
  output logic                        out_last,
  output logic [31:0]                 bit_count
);

  localparam int unsigned D_W    = COEFF_W + 1;
  localparam int unsigned SYM_W  = COEFF_W + 2;
  localparam int unsigned COMP_W = $clog2(NUM_COMP);

  // Predictor state per component
  logic signed [COEFF_W-1:0] prev_dc   [NUM_COMP];
  logic signed [D_W-1:0]     prev_diff [NUM_COMP];
  logic [NUM_COMP-1:0]       first_pending;

  logic stall;
  logic accept;

  logic                  is_first;
  logic signed [D_W-1:0] cur_prev_diff;
  logic signed [D_W-1:0] abs_prev_diff;
  logic signed [D_W-1:0] dc_ext;
  logic signed [D_W-1:0] raw_delta;
  logic signed [D_W-1:0] s1_delta_d;
  codebook_e             s1_cb_d;

  // Pipeline registers
  logic                  s1_valid;
  logic signed [D_W-1:0] s1_delta;
  codebook_e             s1_cb;
  logic [COMP_W-1:0]     s1_comp;
  logic                  s1_last;

  logic                  s1_neg;
  logic [D_W-1:0]        s1_mag;
  logic [SYM_W-1:0]      sym_d;

  logic                  s2_valid;
  logic [SYM_W-1:0]      s2_sym;
  codebook_e             s2_cb;
  logic [COMP_W-1:0]     s2_comp;
  logic                  s2_last;

  logic [CW_W-1:0]       cw_code;
  logic [LEN_W-1:0]      cw_len;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  // S1: delta against the component's predictor, sign adaptation and codebook choice
  always_comb begin
    cur_prev_diff = prev_diff[in_comp];
    is_first      = in_first || first_pending[in_comp];
    dc_ext        = D_W'(in_dc);
    raw_delta     = is_first ? dc_ext : (dc_ext - D_W'(prev_dc[in_comp]));
    abs_prev_diff = (cur_prev_diff < 0) ? -cur_prev_diff : cur_prev_diff;
    if (is_first) begin
      s1_delta_d = raw_delta;
      s1_cb_d    = CB_FIRST;
    end else begin
      s1_delta_d = (cur_prev_diff < 0) ? -raw_delta : raw_delta;
      if (abs_prev_diff == D_W'(0))      s1_cb_d = CB_EG0;
      else if (abs_prev_diff == D_W'(1)) s1_cb_d = CB_EG1;
      else if (abs_prev_diff == D_W'(2)) s1_cb_d = CB_HYB;
      else                               s1_cb_d = CB_EG3;
    end
  end

  // Predictor update, only on an accepted DC
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_COMP; i++) begin
        prev_dc[i]   <= '0;
        prev_diff[i] <= D_W'(FIRST_PREV_DIFF);
      end
      first_pending <= '1;
    end else if (accept) begin
      prev_dc[in_comp]       <= in_dc;
      prev_diff[in_comp]     <= is_first ? D_W'(FIRST_PREV_DIFF) : raw_delta;
      first_pending[in_comp] <= 1'b0;
    end
  end

  // S2: signed delta -> unsigned symbol (0,-1,1,-2,... -> 0,1,2,3,...)
  always_comb begin
    s1_neg = s1_delta < 0;
    s1_mag = s1_neg ? -s1_delta : s1_delta;
    sym_d  = {s1_mag, 1'b0} - SYM_W'(s1_neg);
  end

  prores_codeword_gen #(
    .SYM_W   (SYM_W),
    .CW_W    (CW_W),
    .LEN_W   (LEN_W),
    .FIRST_K (FIRST_K)
  ) u_codeword_gen (
    .sym  (s2_sym),
    .cb   (s2_cb),
    .code (cw_code),
    .len  (cw_len)
  );

  // Three-stage pipeline; every stage holds while the output is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_delta  <= '0;
      s1_cb     <= CB_FIRST;
      s1_comp   <= '0;
      s1_last   <= 1'b0;
      s2_valid  <= 1'b0;
      s2_sym    <= '0;
      s2_cb     <= CB_FIRST;
      s2_comp   <= '0;
      s2_last   <= 1'b0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_len   <= '0;
      out_comp  <= '0;
      out_last  <= 1'b0;
    end else if (!stall) begin
      s1_valid  <= accept;
      s1_delta  <= s1_delta_d;
      s1_cb     <= s1_cb_d;
      s1_comp   <= in_comp;
      s1_last   <= in_last;
      s2_valid  <= s1_valid;
      s2_sym    <= sym_d;
      s2_cb     <= s1_cb;
      s2_comp   <= s1_comp;
      s2_last   <= s1_last;
      out_valid <= s2_valid;
      out_code  <= cw_code;
      out_len   <= cw_len;
      out_comp  <= s2_comp;
      out_last  <= s2_last;
    end
  end

  // Running bit total of delivered codewords (wraps naturally)
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_count <= '0;
    end else if (out_valid && out_ready) begin
      bit_count <= bit_count + 32'(out_len);
    end
  end

endmodule

// File: tb/tb_prores_dc_entropy_encoder.sv
// Directed self-checking bench for prores_dc_entropy_encoder.
module tb_prores_dc_entropy_encoder;

  typedef struct {
    logic [47:0] code;
    logic [5:0]  len;
    logic [1:0]  comp;
    logic        last;
  } out_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic signed [19:0] in_dc;
  logic [1:0]        in_comp;
  logic              in_first;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [47:0]       out_code;
  logic [5:0]        out_len;
  logic [1:0]        out_comp;
  logic              out_last;
  logic [31:0]       bit_count;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  out_t outq[$];

  prores_dc_entropy_encoder #(
    .COEFF_W  (20),
    .NUM_COMP (3),
    .FIRST_K  (5),
    .CW_W     (48),
    .LEN_W    (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dc     (in_dc),
    .in_comp   (in_comp),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_len   (out_len),
    .out_comp  (out_comp),
    .out_last  (out_last),
    .bit_count (bit_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record each codeword that will transfer on the coming rising edge
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      outq.push_back('{out_code, out_len, out_comp, out_last});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_dc(input int dc, input int comp, input bit first, input bit last);
    int waits;
    in_valid = 1'b1;
    in_dc    = 20'(dc);
    in_comp  = 2'(comp);
    in_first = first;
    in_last  = last;
    waits    = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 100) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waits);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input int n, input string name);
    int c;
    c = 0;
    while (outq.size() < n && c < 200) begin
      @(posedge clk);
      #2;
      c++;
    end
    tests++;
    if (outq.size() != n) begin
      fails++;
      $display("FAIL %s_count: got %0d outputs, required %0d", name, outq.size(), n);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_dc     = '0;
    in_comp   = '0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_out_valid: got %0b, required 0", out_valid);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
    end
    tests++;
    if (bit_count !== 32'd0) begin
      fails++;
      $display("FAIL reset_bit_count: got %0d, required 0", bit_count);
    end
    tests++;
    if (out_code !== 48'd0 || out_len !== 6'd0 || out_comp !== 2'd0 || out_last !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got code=%0h len=%0d comp=%0d last=%0b, required all 0",
               out_code, out_len, out_comp, out_last);
    end
    reset = 1'b0;
  endtask

  task automatic test_first_dc();
    out_t o;
    drive_dc(100, 0, 1'b1, 1'b0);
    wait_out(1, "first_dc");
    if (outq.size() > 0) begin
      o = outq.pop_front();
      tests++;
      if (o.len !== 6'd10 || o.code !== 48'h0E8 || o.comp !== 2'd0 || o.last !== 1'b0) begin
        fails++;
        $display("FAIL first_dc: got len=%0d code=%0h comp=%0d last=%0b, required len=10 code=e8 comp=0 last=0",
                 o.len, o.code, o.comp, o.last);
      end
    end
  endtask

  task automatic test_back_to_back_adapt();
    int exp_len [4] = '{4, 4, 4, 6};
    int exp_code[4] = '{14, 9, 5, 10};
    int c0;
    c0 = cyc;
    drive_dc(103, 0, 1'b0, 1'b0);
    drive_dc(102, 0, 1'b0, 1'b0);
    drive_dc(104, 0, 1'b0, 1'b0);
    drive_dc(109, 0, 1'b0, 1'b0);
    tests++;
    if (cyc - c0 != 4) begin
      fails++;
      $display("FAIL back_to_back_cycles: got %0d cycles for 4 DCs, required 4", cyc - c0);
    end
    wait_out(4, "adapt");
    for (int i = 0; i < 4; i++) begin
      out_t o;
      if (outq.size() == 0) break;
      o = outq.pop_front();
      tests++;
      if (o.len !== 6'(exp_len[i]) || o.code !== 48'(exp_code[i]) || o.comp !== 2'd0) begin
        fails++;
        $display("FAIL adapt[%0d]: got len=%0d code=%0h comp=%0d, required len=%0d code=%0h comp=0",
                 i, o.len, o.code, o.comp, exp_len[i], exp_code[i]);
      end
    end
  endtask

  task automatic test_hybrid_rice();
    int exp_len [2] = '{4, 3};
    int exp_code[2] = '{12, 6};
    bit exp_last[2] = '{1'b0, 1'b1};
    drive_dc(111, 0, 1'b0, 1'b0);
    drive_dc(112, 0, 1'b0, 1'b1);
    wait_out(2, "rice");
    for (int i = 0; i < 2; i++) begin
      out_t o;
      if (outq.size() == 0) break;
      o = outq.pop_front();
      tests++;
      if (o.len !== 6'(exp_len[i]) || o.code !== 48'(exp_code[i]) || o.last !== exp_last[i]) begin
        fails++;
        $display("FAIL rice[%0d]: got len=%0d code=%0h last=%0b, required len=%0d code=%0h last=%0b",
                 i, o.len, o.code, o.last, exp_len[i], exp_code[i], exp_last[i]);
      end
    end
    tests++;
    if (bit_count !== 32'd35) begin
      fails++;
      $display("FAIL rice_bit_count: got %0d, required 35", bit_count);
    end
  endtask

  task automatic test_interleave();
    int exp_len [5] = '{10, 6, 4, 4, 4};
    int exp_code[5] = '{131, 46, 5, 12, 8};
    int exp_comp[5] = '{1, 2, 0, 1, 2};
    drive_dc(-50, 1, 1'b1, 1'b0);
    drive_dc(7,   2, 1'b1, 1'b0);
    drive_dc(110, 0, 1'b0, 1'b0);
    drive_dc(-48, 1, 1'b0, 1'b0);
    drive_dc(7,   2, 1'b0, 1'b0);
    wait_out(5, "interleave");
    for (int i = 0; i < 5; i++) begin
      out_t o;
      if (outq.size() == 0) break;
      o = outq.pop_front();
      tests++;
      if (o.len !== 6'(exp_len[i]) || o.code !== 48'(exp_code[i]) || o.comp !== 2'(exp_comp[i])) begin
        fails++;
        $display("FAIL interleave[%0d]: got len=%0d code=%0h comp=%0d, required len=%0d code=%0h comp=%0d",
                 i, o.len, o.code, o.comp, exp_len[i], exp_code[i], exp_comp[i]);
      end
    end
    tests++;
    if (bit_count !== 32'd63) begin
      fails++;
      $display("FAIL interleave_bit_count: got %0d, required 63", bit_count);
    end
  endtask

  task automatic test_stall();
    int exp_len [6] = '{1, 3, 4, 3, 3, 8};
    int exp_code[6] = '{1, 3, 5, 4, 4, 16};
    int exp_comp[6] = '{2, 2, 2, 2, 0, 1};
    bit exp_last[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [47:0] held_code;
    logic [5:0]  held_len;
    logic [31:0] held_bits;
    bit          saw_low;
    int          c;
    saw_low   = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        drive_dc(7,   2, 1'b0, 1'b0);
        drive_dc(8,   2, 1'b0, 1'b0);
        drive_dc(6,   2, 1'b0, 1'b0);
        drive_dc(6,   2, 1'b0, 1'b0);
        drive_dc(110, 0, 1'b0, 1'b0);
        drive_dc(-40, 1, 1'b0, 1'b1);
      end
      begin
        c = 0;
        do begin
          @(negedge clk);
          c++;
        end while (!out_valid && c < 20);
        held_code = out_code;
        held_len  = out_len;
        held_bits = bit_count;
        repeat (5) begin
          @(negedge clk);
          if (!in_ready) saw_low = 1'b1;
          tests++;
          if (out_valid !== 1'b1 || out_code !== held_code || out_len !== held_len ||
              bit_count !== held_bits) begin
            fails++;
            $display("FAIL stall_hold: got valid=%0b code=%0h len=%0d bits=%0d, required valid=1 code=%0h len=%0d bits=%0d",
                     out_valid, out_code, out_len, bit_count, held_code, held_len, held_bits);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    tests++;
    if (!saw_low) begin
      fails++;
      $display("FAIL stall_in_ready: got in_ready=1 throughout stall, required 0");
    end
    wait_out(6, "stall");
    for (int i = 0; i < 6; i++) begin
      out_t o;
      if (outq.size() == 0) break;
      o = outq.pop_front();
      tests++;
      if (o.len !== 6'(exp_len[i]) || o.code !== 48'(exp_code[i]) ||
          o.comp !== 2'(exp_comp[i]) || o.last !== exp_last[i]) begin
        fails++;
        $display("FAIL stall[%0d]: got len=%0d code=%0h comp=%0d last=%0b, required len=%0d code=%0h comp=%0d last=%0b",
                 i, o.len, o.code, o.comp, o.last, exp_len[i], exp_code[i], exp_comp[i], exp_last[i]);
      end
    end
    tests++;
    if (bit_count !== 32'd85) begin
      fails++;
      $display("FAIL stall_bit_count: got %0d, required 85", bit_count);
    end
  endtask

  task automatic test_reset_midburst();
    int exp_len [2] = '{10, 10};
    int exp_code[2] = '{232, 131};
    int exp_comp[2] = '{0, 1};
    bit exp_last[2] = '{1'b0, 1'b1};
    drive_dc(120, 0, 1'b0, 1'b0);
    drive_dc(121, 0, 1'b0, 1'b0);
    drive_dc(122, 0, 1'b0, 1'b0);
    drive_dc(123, 0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL midreset_out_valid: got %0b, required 0", out_valid);
    end
    tests++;
    if (bit_count !== 32'd0) begin
      fails++;
      $display("FAIL midreset_bit_count: got %0d, required 0", bit_count);
    end
    reset = 1'b0;
    outq.delete();
    drive_dc(100, 0, 1'b0, 1'b0);
    drive_dc(-50, 1, 1'b0, 1'b1);
    wait_out(2, "after_reset");
    for (int i = 0; i < 2; i++) begin
      out_t o;
      if (outq.size() == 0) break;
      o = outq.pop_front();
      tests++;
      if (o.len !== 6'(exp_len[i]) || o.code !== 48'(exp_code[i]) ||
          o.comp !== 2'(exp_comp[i]) || o.last !== exp_last[i]) begin
        fails++;
        $display("FAIL after_reset[%0d]: got len=%0d code=%0h comp=%0d last=%0b, required len=%0d code=%0h comp=%0d last=%0b",
                 i, o.len, o.code, o.comp, o.last, exp_len[i], exp_code[i], exp_comp[i], exp_last[i]);
      end
    end
    tests++;
    if (bit_count !== 32'd20) begin
      fails++;
      $display("FAIL after_reset_bit_count: got %0d, required 20", bit_count);
    end
  endtask

  initial begin
    test_reset();
    test_first_dc();
    test_back_to_back_adapt();
    test_hybrid_rice();
    test_interleave();
    test_stall();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
